// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Optional MULDIV_FAST_MUL_EN makes the four multiply ops single-cycle; divide stays iterative.
module muldiv_sequencer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RD_WIDTH   = 5
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  reqValid,
  input  logic [2:0]            reqOp,
  input  logic [DATA_WIDTH-1:0] reqRs1,
  input  logic [DATA_WIDTH-1:0] reqRs2,
  input  logic [RD_WIDTH-1:0]   reqRd,
  input  logic                  clear,
  output logic                  busy,
  output logic                  resultValid,
  output logic [DATA_WIDTH-1:0] resultData,
  output logic [RD_WIDTH-1:0]   resultRd
);

  localparam int unsigned W    = DATA_WIDTH;
  localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic [RD_WIDTH-1:0] rd_q, rd_d;
  logic                neg_q, neg_d;
  logic [W-1:0]        b_q, b_d;
  logic [2*W-1:0]      acc_q, acc_d;
  logic [W-1:0]        res_data_q, res_data_d;
  logic [RD_WIDTH-1:0] res_rd_q, res_rd_d;

  logic           sgn1, sgn2, s1, s2, div_zero, div_ovf, div_ok;
  logic [W-1:0]   mag1, mag2;
  logic [W:0]     mul_sum, div_diff;
  logic [2*W-1:0] mul_next, div_next, step;

  // Negation is applied to the whole magnitude result so MULH* see the correct high half.
  function automatic logic [W-1:0] select_result(input logic [2*W-1:0] acc,
                                                 input logic [2:0] op, input logic neg);
    logic [2*W-1:0] p;
    logic [W-1:0]   q, r;
    p = neg ? -acc : acc;
    q = neg ? -acc[W-1:0] : acc[W-1:0];
    r = neg ? -acc[2*W-1:W] : acc[2*W-1:W];
    if (!op[2]) select_result = (op[1:0] == 2'b00) ? p[W-1:0] : p[2*W-1:W];
    else        select_result = op[1] ? r : q;
  endfunction

  assign sgn1     = !(reqOp == 3'd3 || reqOp == 3'd5 || reqOp == 3'd7);
  assign sgn2     = (reqOp == 3'd0 || reqOp == 3'd1 || reqOp == 3'd4 || reqOp == 3'd6);
  assign s1       = sgn1 & reqRs1[W-1];
  assign s2       = sgn2 & reqRs2[W-1];
  assign mag1     = s1 ? -reqRs1 : reqRs1;
  assign mag2     = s2 ? -reqRs2 : reqRs2;
  assign div_zero = reqOp[2] && (reqRs2 == {W{1'b0}});
  assign div_ovf  = (reqOp == 3'd4 || reqOp == 3'd6) && (reqRs1 == {1'b1, {(W-1){1'b0}}}) &&
                    (reqRs2 == {W{1'b1}});

  // Multiply: acc = {partial high, remaining multiplier}; divide: acc = {remainder, quotient}.
  assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? b_q : {W{1'b0}})};
  assign mul_next = {mul_sum, acc_q[W-1:1]};
  assign div_diff = acc_q[2*W-1:W-1] - {1'b0, b_q};
  assign div_ok   = !div_diff[W];
  assign div_next = {(div_ok ? div_diff[W-1:0] : acc_q[2*W-2:W-1]), acc_q[W-2:0], div_ok};
  assign step     = op_q[2] ? div_next : mul_next;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*W-1:0] fast_prod;
  assign fast_prod = {{W{1'b0}}, mag1} * {{W{1'b0}}, mag2};
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    rd_d       = rd_q;
    neg_d      = neg_q;
    b_d        = b_q;
    acc_d      = acc_q;
    res_data_d = res_data_q;
    res_rd_d   = res_rd_q;
    unique case (state_q)
      StIdle: begin
        if (reqValid && !clear) begin
          op_d    = reqOp;
          rd_d    = reqRd;
          neg_d   = (reqOp[2] && reqOp[1]) ? s1 : (s1 ^ s2);
          b_d     = mag2;
          acc_d   = {{W{1'b0}}, mag1};
          cnt_d   = '0;
          state_d = StCalc;
          if (div_zero) begin
            res_data_d = reqOp[1] ? reqRs1 : {W{1'b1}};
            res_rd_d   = reqRd;
            state_d    = StDone;
          end else if (div_ovf) begin
            res_data_d = reqOp[1] ? {W{1'b0}} : {1'b1, {(W-1){1'b0}}};
            res_rd_d   = reqRd;
            state_d    = StDone;
          end
`ifdef MULDIV_FAST_MUL_EN
          else if (!reqOp[2]) begin
            res_data_d = select_result(fast_prod, reqOp, s1 ^ s2);
            res_rd_d   = reqRd;
            state_d    = StDone;
          end
`endif
        end
      end
      StCalc: begin
        acc_d = step;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(W - 1)) begin
          res_data_d = select_result(step, op_q, neg_q);
          res_rd_d   = rd_q;
          state_d    = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (clear) begin
      state_d    = StIdle;
      res_data_d = res_data_q;
      res_rd_d   = res_rd_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      op_q       <= '0;
      rd_q       <= '0;
      neg_q      <= 1'b0;
      b_q        <= '0;
      acc_q      <= '0;
      res_data_q <= '0;
      res_rd_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      neg_q      <= neg_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      res_data_q <= res_data_d;
      res_rd_q   <= res_rd_d;
    end
  end

  assign busy        = rstn && ((state_q == StIdle && reqValid && !clear) || state_q == StCalc);
  assign resultValid = rstn && (state_q == StDone) && !clear;
  assign resultData  = res_data_q;
  assign resultRd    = res_rd_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed RV32M corner cases plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_muldiv_sequencer;

  localparam logic [31:0] Min = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rstn, reqValid, clear;
  logic [2:0]  reqOp;
  logic [31:0] reqRs1, reqRs2;
  logic [4:0]  reqRd;
  logic        busy, resultValid;
  logic [31:0] resultData;
  logic [4:0]  resultRd;

  int vectors    = 0;
  int miscompares = 0;
  int pulses     = 0;

  muldiv_sequencer #(.DATA_WIDTH(32), .RD_WIDTH(5)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .reqValid   (reqValid),
    .reqOp      (reqOp),
    .reqRs1     (reqRs1),
    .reqRs2     (reqRs2),
    .reqRd      (reqRd),
    .clear      (clear),
    .busy       (busy),
    .resultValid(resultValid),
    .resultData (resultData),
    .resultRd   (resultRd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (resultValid === 1'b1) pulses <= pulses + 1;

  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa = longint'($signed(a));
    longint      sb = longint'($signed(b));
    logic [63:0] ua = {32'b0, a};
    logic [63:0] ub = {32'b0, b};
    logic [63:0] p;
    int          si = a;
    int          sj = b;
    logic        ovf = (a == Min) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? Min : 32'(si / sj);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(si % sj);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (op[2]) begin
      if (b == 0) return 1;
      if ((op == 3'd4 || op == 3'd6) && a == Min && b == 32'hFFFF_FFFF) return 1;
      return 33;
    end
`ifdef MULDIV_FAST_MUL_EN
    return 1;
`else
    return 33;
`endif
  endfunction

  // Called #1 after a posedge with the unit idle; holds reqValid until DONE has retired.
  task automatic issue_check(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] rd, input string name);
    logic [31:0] exp;
    int          lat;
    exp = ref_model(op, a, b);
    lat = ref_latency(op, a, b);
    reqValid = 1'b1; reqOp = op; reqRs1 = a; reqRs2 = b; reqRd = rd;
    #1;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++; $display("FAIL %s accept_busy: got %b expected 1", name, busy);
    end
    for (int c = 1; c <= lat; c++) begin
      @(posedge clk); #1;
      vectors++;
      if (c < lat) begin
        if (busy !== 1'b1 || resultValid !== 1'b0) begin
          miscompares++;
          $display("FAIL %s calc_cycle%0d: busy=%b valid=%b expected busy=1 valid=0",
                   name, c, busy, resultValid);
        end
      end else begin
        if (resultValid !== 1'b1 || busy !== 1'b0) begin
          miscompares++;
          $display("FAIL %s done_cycle%0d: busy=%b valid=%b expected busy=0 valid=1",
                   name, c, busy, resultValid);
        end
        vectors++;
        if (resultData !== exp) begin
          miscompares++;
          $display("FAIL %s data op=%0d a=%h b=%h: got %h expected %h",
                   name, op, a, b, resultData, exp);
        end
        vectors++;
        if (resultRd !== rd) begin
          miscompares++; $display("FAIL %s rd: got %0d expected %0d", name, resultRd, rd);
        end
      end
    end
    @(posedge clk);
    reqValid = 1'b0;
    #1;
    vectors++;
    if (resultValid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s after_done: busy=%b valid=%b expected 0 0", name, busy, resultValid);
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0; clear = 1'b0;
    reqValid = 1'b1; reqOp = 3'd4; reqRs1 = 32'd77; reqRs2 = 32'd5; reqRd = 5'd3;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0 || resultValid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: busy=%b valid=%b expected 0 0", busy, resultValid);
    end
    vectors++;
    if (resultData !== 32'h0 || resultRd !== 5'h0) begin
      miscompares++;
      $display("FAIL reset_data: data=%h rd=%0d expected 0 0", resultData, resultRd);
    end
    rstn = 1'b1; reqValid = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_no_accept: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_directed;
    @(posedge clk); #1; issue_check(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd5, "div_neg");
    #1; issue_check(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, "rem_neg");
    #1; issue_check(3'd5, 32'd100, 32'd0, 5'd7, "divu_zero");
    #1; issue_check(3'd7, 32'd100, 32'd0, 5'd8, "remu_zero");
    #1; issue_check(3'd4, Min, 32'hFFFF_FFFF, 5'd9, "div_ovf");
    #1; issue_check(3'd6, Min, 32'hFFFF_FFFF, 5'd10, "rem_ovf");
    #1; issue_check(3'd1, Min, Min, 5'd11, "mulh_min");
    #1; issue_check(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, "mulhsu_ones");
    #1; issue_check(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, "mulhu_ones");
    #1; issue_check(3'd0, 32'd7, 32'd6, 5'd14, "mul_small");
    #1; issue_check(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd15, "mul_ones");
    #1; issue_check(3'd4, 32'd5, 32'd0, 5'd16, "div_zero");
  endtask

  task automatic test_clear;
    int p0;
    @(posedge clk); #1;
    reqValid = 1'b1; reqOp = 3'd5; reqRs1 = 32'd1000; reqRs2 = 32'd7; reqRd = 5'd20;
    p0 = pulses;
    repeat (10) @(posedge clk);
    #1;
    clear = 1'b1; reqValid = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++; $display("FAIL clear_calc_busy: got %b expected 1", busy);
    end
    @(posedge clk); #1;
    clear = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || resultValid !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_after: busy=%b valid=%b expected 0 0", busy, resultValid);
    end
    issue_check(3'd5, 32'd9, 32'd3, 5'd21, "after_clear");
    vectors++;
    if (pulses !== p0 + 1) begin
      miscompares++; $display("FAIL clear_pulses: got %0d expected %0d", pulses - p0, 1);
    end
  endtask

  task automatic test_clear_done;
    int p0;
    @(posedge clk); #1;
    reqValid = 1'b1; reqOp = 3'd5; reqRs1 = 32'd5; reqRs2 = 32'd0; reqRd = 5'd2;
    p0 = pulses;
    @(posedge clk); #1;
    clear = 1'b1; reqValid = 1'b0;
    #1;
    vectors++;
    if (resultValid !== 1'b0) begin
      miscompares++; $display("FAIL clear_done_valid: got %b expected 0", resultValid);
    end
    @(posedge clk); #1;
    clear = 1'b0;
    #1;
    vectors++;
    if (pulses !== p0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_done_after: pulses=%0d busy=%b expected 0 0", pulses - p0, busy);
    end
  endtask

  task automatic test_hold_through_done;
    int p0;
    p0 = pulses;
    @(posedge clk); #1;
    issue_check(3'd6, 32'd12345, 32'd17, 5'd30, "hold_rem");
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (pulses !== p0 + 1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_pulses: pulses=%0d busy=%b expected 1 0", pulses - p0, busy);
    end
  endtask

  task automatic test_reset_mid;
    int p0;
    @(posedge clk); #1;
    issue_check(3'd0, 32'd7, 32'd6, 5'd3, "pre_reset_mul");
    #1;
    reqValid = 1'b1; reqOp = 3'd4; reqRs1 = 32'd123456; reqRs2 = 32'd7; reqRd = 5'd4;
    p0 = pulses;
    repeat (5) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || resultValid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_ctrl: busy=%b valid=%b expected 0 0", busy, resultValid);
    end
    @(posedge clk); #1;
    vectors++;
    if (resultData !== 32'h0 || resultRd !== 5'h0) begin
      miscompares++;
      $display("FAIL reset_mid_data: data=%h rd=%0d expected 0 0", resultData, resultRd);
    end
    rstn = 1'b1; reqValid = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0 || pulses !== p0) begin
      miscompares++;
      $display("FAIL reset_mid_after: busy=%b pulses=%0d expected 0 0", busy, pulses - p0);
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return Min;
      4:       return 32'($urandom_range(0, 20));
      5:       return 32'h7FFF_FFFF;
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic test_random;
    logic [2:0]  op;
    logic [31:0] a, b;
    @(posedge clk); #1;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      issue_check(op, a, b, 5'($urandom_range(0, 31)), "random");
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_clear();
    test_clear_done();
    test_hold_through_done();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
